// File: rtl/uart_fifo_ctrl_if.sv
// Byte stream bundle between the UART FIFO controller and its producer/consumer.
// The slave modport is the controller side: it takes upstream strobes and the
// downstream ready, and presents the registered head-of-FIFO word.
interface uart_fifo_ctrl_if #(
   parameter int unsigned WIDTH_MEM = 8
);
   logic                 in_valid;
   logic [WIDTH_MEM-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH_MEM-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output out_valid,
      output out_data
   );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Pointer/handshake controller wrapping an external synchronous dual-port RAM as a
// byte FIFO. Upstream has no backpressure: words arriving while the RAM is full are
// dropped and flagged in a sticky overflow bit. The RAM's one-cycle read latency is
// absorbed by a FETCH state that loads a registered output stage.
module uart_fifo_ctrl #(
   parameter int unsigned WIDTH_MEM = 8,
   parameter int unsigned DEPTH_MEM = 16,
   localparam int unsigned ADDR_W   = $clog2(DEPTH_MEM)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_fifo_ctrl_if.slave      bus,
   input  logic                 clr_overflow,
   output logic [ADDR_W:0]      count,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 mem_wr_enable,
   output logic [ADDR_W-1:0]    mem_wr_address,
   output logic [WIDTH_MEM-1:0] mem_wr_data,
   output logic                 mem_rd_enable,
   output logic [ADDR_W-1:0]    mem_rd_address,
   input  logic [WIDTH_MEM-1:0] mem_rd_data
);
   localparam int unsigned PTR_W = ADDR_W + 1;

   typedef enum logic {StIdle, StFetch} state_e;

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, ram_used;
   logic                 ram_nonempty, fetch, wr_en;
   logic                 out_valid_q;
   logic [WIDTH_MEM-1:0] out_data_q;
   logic                 overflow_q, overflow_d;
   logic                 in_fetch;

   // Extra pointer bit distinguishes full from empty when the addresses coincide.
   assign ram_used     = wr_ptr_q - rd_ptr_q;
   assign full         = (ram_used == PTR_W'(DEPTH_MEM));
   assign ram_nonempty = (ram_used != '0);
   assign in_fetch     = (state_q == StFetch);

   // A write and a fetch can never hit the same address: that needs empty or full.
   assign wr_en          = bus.in_valid && !full;
   assign mem_wr_enable  = wr_en;
   assign mem_wr_address = wr_ptr_q[ADDR_W-1:0];
   assign mem_wr_data    = bus.in_data;
   assign mem_rd_enable  = fetch;
   assign mem_rd_address = rd_ptr_q[ADDR_W-1:0];

   // Occupancy includes the word in flight from the RAM and the output register.
   assign count    = ram_used + {{ADDR_W{1'b0}}, in_fetch} + {{ADDR_W{1'b0}}, out_valid_q};
   assign empty    = (count == '0);
   assign overflow = overflow_q;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   // Fetch issue: only when the output register is free (or emptying) this cycle.
   always_comb begin
      fetch   = 1'b0;
      state_d = StIdle;
      if (ram_nonempty && !in_fetch && (!out_valid_q || bus.out_ready)) begin
         fetch   = 1'b1;
         state_d = StFetch;
      end
   end

   // Sticky overflow; a drop in the same cycle wins over a clear.
   always_comb begin
      overflow_d = overflow_q;
      if (bus.in_valid && full) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // FSM state, pointers and overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (fetch) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Output stage: capture RAM data in FETCH, release on a downstream transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (in_fetch) begin
         out_valid_q <= 1'b1;
         out_data_q  <= mem_rd_data;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl. A behavioural RAM is attached, and a
// queue-based reference model (RAM contents, in-flight word, output register)
// predicts every registered and combinational output each cycle.
module tb_uart_fifo_ctrl;
   localparam int unsigned W = 8;
   localparam int unsigned D = 16;
   localparam int unsigned A = $clog2(D);

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr_overflow;
   logic [A:0]   count;
   logic         full, empty, overflow;
   logic         mem_wr_enable, mem_rd_enable;
   logic [A-1:0] mem_wr_address, mem_rd_address;
   logic [W-1:0] mem_wr_data, mem_rd_data;
   logic [W-1:0] ram [D];

   uart_fifo_ctrl_if #(.WIDTH_MEM(W)) bus ();

   uart_fifo_ctrl #(.WIDTH_MEM(W), .DEPTH_MEM(D)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .clr_overflow   (clr_overflow),
      .count          (count),
      .full           (full),
      .empty          (empty),
      .overflow       (overflow),
      .mem_wr_enable  (mem_wr_enable),
      .mem_wr_address (mem_wr_address),
      .mem_wr_data    (mem_wr_data),
      .mem_rd_enable  (mem_rd_enable),
      .mem_rd_address (mem_rd_address),
      .mem_rd_data    (mem_rd_data)
   );

   always #5 clk = ~clk;

   // Synchronous dual-port RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_wr_enable) ram[mem_wr_address] <= mem_wr_data;
      if (mem_rd_enable) mem_rd_data <= ram[mem_rd_address];
   end

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model state
   logic [W-1:0] ram_q [$];
   logic [W-1:0] got_q [$];
   logic [W-1:0] sent_q [$];
   bit           m_infl, m_ov, m_ovf;
   logic [W-1:0] m_fw, m_od;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      ram_q.delete();
      m_infl = 1'b0;
      m_ov   = 1'b0;
      m_ovf  = 1'b0;
      m_fw   = '0;
      m_od   = '0;
   endtask

   function automatic int model_count();
      return ram_q.size() + int'(m_infl) + int'(m_ov);
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
      chk({tag, "_count"},     32'(count),         32'd0);
      chk({tag, "_full"},      32'(full),          32'd0);
      chk({tag, "_empty"},     32'(empty),         32'd1);
      chk({tag, "_overflow"},  32'(overflow),      32'd0);
      chk({tag, "_rd_en"},     32'(mem_rd_enable), 32'd0);
      chk({tag, "_wr_en"},     32'(mem_wr_enable), 32'(bus.in_valid));
   endtask

   // One clock cycle: drive inputs after the falling edge, check against the model,
   // advance the model by the cycle's transaction rules, then wait for the next fall.
   task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic clr);
      bit m_full, fetch, m_wr;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      clr_overflow  = clr;
      #1;
      m_full = (ram_q.size() == D);
      fetch  = (ram_q.size() != 0) && !m_infl && (!m_ov || ordy);
      m_wr   = iv && !m_full;
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("out_data",  32'(bus.out_data),  32'(m_od));
      chk("count",     32'(count),         32'(model_count()));
      chk("full",      32'(full),          32'(m_full));
      chk("empty",     32'(empty),         32'(model_count() == 0));
      chk("overflow",  32'(overflow),      32'(m_ovf));
      chk("wr_en",     32'(mem_wr_enable), 32'(m_wr));
      chk("rd_en",     32'(mem_rd_enable), 32'(fetch));
      if (bus.out_valid && ordy) got_q.push_back(bus.out_data);
      if (m_infl) begin
         m_ov = 1'b1;
         m_od = m_fw;
      end else if (m_ov && ordy) begin
         m_ov = 1'b0;
      end
      if (fetch) begin
         m_fw   = ram_q.pop_front();
         m_infl = 1'b1;
      end else begin
         m_infl = 1'b0;
      end
      if (m_wr) ram_q.push_back(id);
      if (iv && m_full) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && model_count() != 0; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_done", 32'(model_count()), 32'd0);
   endtask

   initial begin
      logic [W-1:0] d;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      clr_overflow  = 1'b0;
      reset_model();
      #2;
      check_reset_vals("reset");
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single word latency: written in N, visible in N+3.
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_data",  32'(bus.out_data),  32'hA5);
      chk("single_count", 32'(count),         32'd1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("single_count0", 32'(count), 32'd0);
      chk("single_empty",  32'(empty), 32'd1);

      // Fill past capacity with no downstream acceptance.
      for (int i = 0; i < 18; i++) step(1'b1, W'(i), 1'b0, 1'b0);
      chk("fill_full",     32'(full),          32'd1);
      chk("fill_count",    32'(count),         32'd17);
      chk("fill_overflow", 32'(overflow),      32'd1);
      chk("fill_head",     32'(bus.out_data),  32'h00);
      chk("fill_valid",    32'(bus.out_valid), 32'd1);

      // Clear racing a drop keeps the flag; a lone clear drops it.
      step(1'b1, 8'h55, 1'b0, 1'b1);
      chk("clr_vs_drop", 32'(overflow), 32'd1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clr_alone", 32'(overflow), 32'd0);

      got_q.delete();
      drain(80);
      chk("fill_drain_n", 32'(got_q.size()), 32'd17);
      foreach (got_q[i]) chk("fill_order", 32'(got_q[i]), 32'(i));

      // Wrap-around stream with random backpressure.
      got_q.delete();
      sent_q.delete();
      for (int c = 0; c < 120; c++) begin
         d = W'($urandom);
         if (c % 3 == 0) begin
            sent_q.push_back(d);
            step(1'b1, d, 1'($urandom_range(0, 1)), 1'b0);
         end else begin
            step(1'b0, d, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      drain(80);
      chk("wrap_n",        32'(got_q.size()), 32'd40);
      chk("wrap_overflow", 32'(overflow),     32'd0);
      foreach (sent_q[i]) if (i < got_q.size()) chk("wrap_order", 32'(got_q[i]), 32'(sent_q[i]));

      // Backpressure hold with more data waiting in RAM.
      step(1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b1, 8'h88, 1'b0, 1'b0);
      for (int i = 0; i < 10 && !bus.out_valid; i++) step(1'b0, '0, 1'b0, 1'b0);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         chk("hold_data",  32'(bus.out_data),  32'h77);
         chk("hold_rd_en", 32'(mem_rd_enable), 32'd0);
      end
      drain(40);

      // Reset while a fetch is in flight.
      for (int i = 0; i < 5; i++) step(1'b1, W'(8'h90 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10 && !m_infl; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("rst_in_fetch", 32'(m_infl), 32'd1);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      reset_model();
      got_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      drain(20);
      chk("rst_first_n", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("rst_first_data", 32'(got_q[0]), 32'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
